mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one single-port unified instruction/data memory between the fetch port (IF) and the load/store port (LS) of the RV32I core. Arbitrates requests, issues one memory access at a time, counts out the fixed memory latency and returns read data or a write acknowledge to the winning requester. It sits between the PC/fetch logic, the load/store path driven by the control word (lw/sw bits), and the memory macro.

## Interface
- `ADDR_W`, 32: address width, byte address.
- `DATA_W`, 32: data width.
- `WAIT_CYC`, 1: memory read latency in cycles, legal range 1..15.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch request, held until `if_gnt`.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: fetch data valid, one-cycle pulse.
- `if_rdata` out DATA_W: fetch data, 0 when `if_rvalid`=0.
- `ls_req` in 1: load/store request, held until `ls_gnt`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_be` in 4: byte enables for stores.
- `ls_addr` in ADDR_W: load/store address.
- `ls_wdata` in DATA_W: store data.
- `ls_gnt` out 1: load/store accepted this cycle.
- `ls_rvalid` out 1: load data valid / store ack, one-cycle pulse.
- `ls_rdata` out DATA_W: load data, 0 when `ls_rvalid`=0 or for store ack.
- `mem_en` out 1: memory access strobe.
- `mem_we` out 1: memory write.
- `mem_be` out 4: memory byte enables (4'b1111 for IF and loads).
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_rdata` in DATA_W: memory read data, valid `WAIT_CYC` cycles after the `mem_en` cycle.
- `busy` out 1: an access is outstanding.

## Operation
- States: IDLE, BUSY. Registers: state, `cnt` (4 bits), `owner` (IF/LS), `owner_we`, `last_owner`.
- Grant is combinational: possible when state=IDLE, or state=BUSY with `cnt`=0 (response cycle). Winner's `gnt` asserts, `mem_en`=1, mem_* driven from winner's inputs, same cycle.
- On grant: state<=BUSY, `cnt`<=WAIT_CYC-1, `owner`<=winner, `owner_we`<=winner write flag, `last_owner`<=winner.
- In BUSY, `cnt`>0: decrement, no grant.
- In BUSY, `cnt`=0: response cycle. Owner's `rvalid`=1; `rdata`=`mem_rdata` for reads, 0 for store ack. If no new grant this cycle, state<=IDLE.
- Arbitration (default): LS has fixed priority over IF.
- `mem_en`=0 implies `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
- `busy` = (state=BUSY).
- A request dropped before its grant has no effect. Inputs are sampled only in the grant cycle.
- IF never writes: `mem_we`=0 for IF grants.

## Timing
- Reset (async assert): state=IDLE, `cnt`=0, `owner`=IF, `last_owner`=IF. All `gnt`, `rvalid`, `mem_en`, `busy` are 0, and all data outputs are 0. An in-flight access is discarded: no `rvalid`, and late `mem_rdata` is ignored.
- Grant in cycle T: the response (`rvalid`) appears in cycle T+WAIT_CYC.
- Throughput: one access per WAIT_CYC cycles. With WAIT_CYC=1, back-to-back grants every cycle.
- Simultaneous response and new grant in the same cycle is legal. The new grant's `owner` update does not disturb the current cycle's `rvalid` routing.
- Requests in a non-grant BUSY cycle wait, with no `gnt` asserted.

## Configuration
- `MEM_ARB_RR_EN` defined: when both request in a grant cycle, the winner is the requester that is not `last_owner`. Because `last_owner` resets to IF, the first contention goes to LS. A lone requester always wins.
- Not defined: fixed LS priority, and `last_owner` is unused.

## Test plan
- WAIT_CYC=2, `if_req`=1, `if_addr`=0x100 at T, `mem_rdata`=0x00000013 at T+2 -> `if_gnt` at T, `mem_en`=1/`mem_addr`=0x100/`mem_be`=4'hF at T, `if_rvalid`=1 with `if_rdata`=0x13 at T+2, `busy`=1 at T+1..T+2.
- WAIT_CYC=1, `if_req` and `ls_req` (load, 0x2000) both at T, fixed priority -> `ls_gnt` at T, `if_gnt` at T+1, `ls_rvalid` at T+1, `if_rvalid` at T+2.
- WAIT_CYC=1, store `ls_we`=1, `ls_be`=4'b0011, `ls_wdata`=0xDEADBEEF -> `mem_we`=1, `mem_be`=4'b0011, `mem_wdata`=0xDEADBEEF at grant; `ls_rvalid`=1 with `ls_rdata`=0 one cycle later.
- WAIT_CYC=1, `if_req` held high for 6 cycles -> 6 consecutive `if_gnt`, with `if_rvalid` in each of cycles T+1..T+6.
- `MEM_ARB_RR_EN`, WAIT_CYC=1, both requesting continuously -> grants alternate LS, IF, LS, IF.
- WAIT_CYC=3, grant at T, `rst_n`=0 at T+1 and released at T+2 -> no `rvalid` at T+3, `busy`=0 from T+1, and the next request is granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (LS) ports.
// Define MEM_ARB_RR_EN to replace fixed LS priority with round-robin on contention.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);
    localparam logic       OWN_IF   = 1'b0;
    localparam logic       OWN_LS   = 1'b1;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt;
    logic       r_owner, w_owner_nxt;
    logic       r_owner_we, w_owner_we_nxt;
`ifdef MEM_ARB_RR_EN
    logic       r_last_owner, w_last_owner_nxt;
`endif

    logic w_resp;
    logic w_can_grant;
    logic w_pick_ls;
    logic w_gnt_if;
    logic w_gnt_ls;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_owner      <= OWN_IF;
            r_owner_we   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_owner <= OWN_IF;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_owner_we   <= w_owner_we_nxt;
`ifdef MEM_ARB_RR_EN
            r_last_owner <= w_last_owner_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_owner_nxt    = r_owner;
        w_owner_we_nxt = r_owner_we;
`ifdef MEM_ARB_RR_EN
        w_last_owner_nxt = r_last_owner;
`endif
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;

        // The response cycle doubles as a grant slot so WAIT_CYC=1 sustains one access per cycle.
        w_resp      = (r_state == S_BUSY) && (r_cnt == 4'd0);
        w_can_grant = rst_n && ((r_state == S_IDLE) || w_resp);

`ifdef MEM_ARB_RR_EN
        if (ls_req && if_req) w_pick_ls = (r_last_owner == OWN_IF);
        else                  w_pick_ls = ls_req;
`else
        w_pick_ls = ls_req;
`endif
        w_gnt_ls = w_can_grant && ls_req && w_pick_ls;
        w_gnt_if = w_can_grant && if_req && !w_pick_ls;

        // Response routing uses the registered owner, untouched by a same-cycle grant.
        if (w_resp) begin
            if (r_owner == OWN_IF) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end else begin
                ls_rvalid = 1'b1;
                if (!r_owner_we) ls_rdata = mem_rdata;
            end
        end

        if (w_gnt_ls) begin
            ls_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_we   = ls_we;
            mem_be   = ls_we ? ls_be : 4'b1111;
            mem_addr = ls_addr;
            if (ls_we) mem_wdata = ls_wdata;
        end else if (w_gnt_if) begin
            if_gnt   = 1'b1;
            mem_en   = 1'b1;
            mem_be   = 4'b1111;
            mem_addr = if_addr;
        end

        if (w_gnt_ls || w_gnt_if) begin
            w_state_nxt    = S_BUSY;
            w_cnt_nxt      = CNT_INIT;
            w_owner_nxt    = w_gnt_ls ? OWN_LS : OWN_IF;
            w_owner_we_nxt = w_gnt_ls && ls_we;
`ifdef MEM_ARB_RR_EN
            w_last_owner_nxt = w_gnt_ls ? OWN_LS : OWN_IF;
`endif
        end else if (r_state == S_BUSY) begin
            if (r_cnt != 4'd0) w_cnt_nxt   = r_cnt - 4'd1;
            else               w_state_nxt = S_IDLE;
        end
    end

    assign busy = (r_state == S_BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: instance 0 has WAIT_CYC=1, instance 1 has WAIT_CYC=3.
// Expectations are queued by the stimulus; one monitor compares at every falling edge.
module tb_mem_arbiter;

    typedef struct packed {
        int          cyc;
        logic        port;   // 1 = LS, 0 = IF; busy value for busy entries
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk;
    logic        rst_n;
    int          cyc;
    bit          done;
    int          total;
    int          passed;

    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        if_gnt    [2];
    logic        if_rvalid [2];
    logic [31:0] if_rdata  [2];
    logic        ls_req    [2];
    logic        ls_we     [2];
    logic [3:0]  ls_be     [2];
    logic [31:0] ls_addr   [2];
    logic [31:0] ls_wdata  [2];
    logic        ls_gnt    [2];
    logic        ls_rvalid [2];
    logic [31:0] ls_rdata  [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [3:0]  mem_be    [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    ev_t gq [2][$];
    ev_t rq [2][$];
    ev_t bq [2][$];

    logic [31:0] sched   [2][64];
    bit          sched_v [2][64];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(g == 0 ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_gnt(if_gnt[g]),
            .if_rvalid(if_rvalid[g]), .if_rdata(if_rdata[g]),
            .ls_req(ls_req[g]), .ls_we(ls_we[g]), .ls_be(ls_be[g]), .ls_addr(ls_addr[g]),
            .ls_wdata(ls_wdata[g]), .ls_gnt(ls_gnt[g]), .ls_rvalid(ls_rvalid[g]),
            .ls_rdata(ls_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_be(mem_be[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] lookup(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0000_0013;
            32'h0000_0104: return 32'h0050_0093;
            32'h0000_2000: return 32'h1234_5678;
            default:       return 32'hE0E0_0000 ^ a;
        endcase
    endfunction

    // Memory model: read data appears WAIT_CYC cycles after the access, garbage otherwise.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_en[i] === 1'b1 && mem_we[i] === 1'b0) begin
                sched[i][(cyc + wc(i)) % 64]   = lookup(mem_addr[i]);
                sched_v[i][(cyc + wc(i)) % 64] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (sched_v[i][cyc % 64]) mem_rdata[i] = sched[i][cyc % 64];
            else                      mem_rdata[i] = 32'hBAD0_0000 | 32'(cyc);
            sched_v[i][cyc % 64] = 1'b0;
        end
    end

    function automatic void chk(input string nm, input int i, input logic [71:0] act,
                                input logic [71:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", nm, i, cyc, act, exp);
    endfunction

    function automatic void miss(input string nm, input int i, input int c);
        total++;
        $display("FAIL missing_%s[%0d] cyc=%0d got=none expected=event at cyc %0d", nm, i, cyc, c);
    endfunction

    function automatic void extra(input string nm, input int i);
        total++;
        $display("FAIL unexpected_%s[%0d] cyc=%0d got=event expected=none", nm, i, cyc);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            ev_t e;
            while (gq[i].size() > 0 && gq[i][0].cyc < cyc) begin
                e = gq[i].pop_front();
                miss("gnt", i, e.cyc);
            end
            if (if_gnt[i] !== 1'b0 || ls_gnt[i] !== 1'b0) begin
                if (gq[i].size() > 0 && gq[i][0].cyc == cyc) begin
                    e = gq[i].pop_front();
                    chk("gnt_sel", i, 72'({ls_gnt[i], if_gnt[i]}), 72'({e.port, ~e.port}));
                    chk("mem_ctl", i, 72'({mem_en[i], mem_we[i], mem_be[i]}),
                        72'({1'b1, e.we, e.be}));
                    chk("mem_addr", i, 72'(mem_addr[i]), 72'(e.addr));
                    chk("mem_wdata", i, 72'(mem_wdata[i]), 72'(e.data));
                end else extra("gnt", i);
            end else begin
                chk("mem_idle", i, 72'({mem_en[i], mem_we[i], mem_be[i], mem_addr[i], mem_wdata[i]}),
                    72'(0));
            end

            while (rq[i].size() > 0 && rq[i][0].cyc < cyc) begin
                e = rq[i].pop_front();
                miss("rsp", i, e.cyc);
            end
            if (if_rvalid[i] !== 1'b0 || ls_rvalid[i] !== 1'b0) begin
                if (rq[i].size() > 0 && rq[i][0].cyc == cyc) begin
                    e = rq[i].pop_front();
                    chk("rsp_sel", i, 72'({ls_rvalid[i], if_rvalid[i]}), 72'({e.port, ~e.port}));
                    chk("rdata", i, 72'({ls_rdata[i], if_rdata[i]}),
                        e.port ? 72'({e.data, 32'h0}) : 72'({32'h0, e.data}));
                end else extra("rsp", i);
            end else begin
                chk("rdata_idle", i, 72'({ls_rdata[i], if_rdata[i]}), 72'(0));
            end

            while (bq[i].size() > 0 && bq[i][0].cyc < cyc) begin
                e = bq[i].pop_front();
                miss("busy", i, e.cyc);
            end
            if (bq[i].size() > 0 && bq[i][0].cyc == cyc) begin
                e = bq[i].pop_front();
                chk("busy", i, 72'(busy[i]), 72'(e.port));
            end

            if (done) begin
                while (gq[i].size() > 0) begin e = gq[i].pop_front(); miss("gnt", i, e.cyc); end
                while (rq[i].size() > 0) begin e = rq[i].pop_front(); miss("rsp", i, e.cyc); end
                while (bq[i].size() > 0) begin e = bq[i].pop_front(); miss("busy", i, e.cyc); end
            end
        end
    end

    function automatic void exp_gnt(input int i, input int c, input logic port, input logic we,
                                    input logic [3:0] be, input logic [31:0] addr,
                                    input logic [31:0] data);
        gq[i].push_back('{c, port, we, be, addr, data});
    endfunction

    function automatic void exp_rsp(input int i, input int c, input logic port,
                                    input logic [31:0] data);
        rq[i].push_back('{c, port, 1'b0, 4'h0, 32'h0, data});
    endfunction

    function automatic void exp_busy(input int i, input int c, input logic b);
        bq[i].push_back('{c, b, 1'b0, 4'h0, 32'h0, 32'h0});
    endfunction

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        cyc    = 0;
        done   = 1'b0;
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 1'b0; if_addr[i] = '0;
            ls_req[i] = 1'b0; ls_we[i] = 1'b0; ls_be[i] = '0; ls_addr[i] = '0; ls_wdata[i] = '0;
            mem_rdata[i] = '0;
            exp_busy(i, 1, 1'b0);
        end
        exp_busy(1, 5, 1'b0); exp_busy(1, 6, 1'b1); exp_busy(1, 7, 1'b1);
        exp_busy(1, 8, 1'b1); exp_busy(1, 9, 1'b0);

        goto(2);
        rst_n = 1'b1;

        // Single fetch on the slow instance; contention on the fast one
        goto(5);
        if_req[1] = 1'b1; if_addr[1] = 32'h100;
        exp_gnt(1, 5, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
        exp_rsp(1, 8, 1'b0, 32'h0000_0013);
        if_req[0] = 1'b1; if_addr[0] = 32'h104;
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 32'h2000;
        exp_gnt(0, 5, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
        exp_gnt(0, 6, 1'b0, 1'b0, 4'hF, 32'h104, 32'h0);
        exp_rsp(0, 6, 1'b1, 32'h1234_5678);
        exp_rsp(0, 7, 1'b0, 32'h0050_0093);
        goto(6);
        if_req[1] = 1'b0;
        ls_req[0] = 1'b0;
        goto(7);
        if_req[0] = 1'b0;

        // Store with partial byte enables
        goto(9);
        ls_req[0] = 1'b1; ls_we[0] = 1'b1; ls_be[0] = 4'b0011;
        ls_addr[0] = 32'h3000; ls_wdata[0] = 32'hDEAD_BEEF;
        exp_gnt(0, 9, 1'b1, 1'b1, 4'b0011, 32'h3000, 32'hDEAD_BEEF);
        exp_rsp(0, 10, 1'b1, 32'h0);
        goto(10);
        ls_req[0] = 1'b0; ls_we[0] = 1'b0; ls_be[0] = '0; ls_addr[0] = '0; ls_wdata[0] = '0;

        // Six back-to-back fetches
        exp_busy(0, 12, 1'b0); exp_busy(0, 13, 1'b1);
        exp_busy(0, 18, 1'b1); exp_busy(0, 19, 1'b0);
        for (int k = 0; k < 6; k++) begin
            goto(12 + k);
            if_req[0]  = 1'b1;
            if_addr[0] = (k % 2 == 1) ? 32'h104 : 32'h100;
            exp_gnt(0, 12 + k, 1'b0, 1'b0, 4'hF, if_addr[0], 32'h0);
            exp_rsp(0, 13 + k, 1'b0, (k % 2 == 1) ? 32'h0050_0093 : 32'h0000_0013);
        end
        goto(18);
        if_req[0] = 1'b0;

        // Continuous contention; the losing fetch is withdrawn unserved under fixed priority
        goto(21);
        if_req[0] = 1'b1; if_addr[0] = 32'h100;
        ls_req[0] = 1'b1; ls_we[0] = 1'b0; ls_addr[0] = 32'h2000;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            if (k % 2 == 1) begin
                exp_gnt(0, 21 + k, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
                exp_rsp(0, 22 + k, 1'b0, 32'h0000_0013);
            end else begin
                exp_gnt(0, 21 + k, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
                exp_rsp(0, 22 + k, 1'b1, 32'h1234_5678);
            end
`else
            exp_gnt(0, 21 + k, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
            exp_rsp(0, 22 + k, 1'b1, 32'h1234_5678);
`endif
        end
        goto(25);
        if_req[0] = 1'b0; ls_req[0] = 1'b0;

        // Reset during an in-flight access on the slow instance
        goto(30);
        if_req[1] = 1'b1; if_addr[1] = 32'h104;
        exp_gnt(1, 30, 1'b0, 1'b0, 4'hF, 32'h104, 32'h0);
        exp_busy(1, 30, 1'b0); exp_busy(1, 31, 1'b0);
        exp_busy(1, 32, 1'b0); exp_busy(1, 33, 1'b0);
        goto(31);
        rst_n = 1'b0;
        if_req[1] = 1'b0;
        if_req[0] = 1'b1; if_addr[0] = 32'h100;
        exp_gnt(0, 32, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
        exp_rsp(0, 33, 1'b0, 32'h0000_0013);
        goto(32);
        rst_n = 1'b1;
        goto(33);
        if_req[0] = 1'b0;

        goto(35);
        ls_req[1] = 1'b1; ls_we[1] = 1'b0; ls_addr[1] = 32'h2000;
        exp_gnt(1, 35, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
        exp_rsp(1, 38, 1'b1, 32'h1234_5678);
        exp_busy(1, 36, 1'b1);
        goto(36);
        ls_req[1] = 1'b0;

        // Store waits through BUSY and is granted in the fetch's response cycle
        goto(40);
        if_req[1] = 1'b1; if_addr[1] = 32'h100;
        exp_gnt(1, 40, 1'b0, 1'b0, 4'hF, 32'h100, 32'h0);
        exp_gnt(1, 43, 1'b1, 1'b1, 4'b1100, 32'h3004, 32'hCAFE_F00D);
        exp_rsp(1, 43, 1'b0, 32'h0000_0013);
        exp_rsp(1, 46, 1'b1, 32'h0);
        exp_busy(1, 41, 1'b1); exp_busy(1, 44, 1'b1);
        exp_busy(1, 46, 1'b1); exp_busy(1, 47, 1'b0);
        goto(41);
        if_req[1] = 1'b0;
        ls_req[1] = 1'b1; ls_we[1] = 1'b1; ls_be[1] = 4'b1100;
        ls_addr[1] = 32'h3004; ls_wdata[1] = 32'hCAFE_F00D;
        goto(44);
        ls_req[1] = 1'b0; ls_we[1] = 1'b0; ls_be[1] = '0; ls_addr[1] = '0; ls_wdata[1] = '0;

        goto(50);
        done = 1'b1;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
